// File: rtl/input_trigger_pkg.sv
// Shared definitions for the input trigger sequencer: FSM state encoding,
// edge selection codes and the counter width helper.
package input_trigger_pkg;

  typedef enum logic [2:0] {
    ST_READY   = 3'd0,
    ST_INC     = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_REFRESH = 3'd3,
    ST_BLOCK   = 3'd4,
    ST_HOLD    = 3'd5
  } state_e;

  localparam logic [1:0] EDGE_RISE = 2'b00;
  localparam logic [1:0] EDGE_FALL = 2'b01;
  localparam logic [1:0] EDGE_BOTH = 2'b10;
  localparam logic [1:0] EDGE_NONE = 2'b11;

  // Smallest counter width able to hold the largest of the three interval lengths.
  function automatic int unsigned cnt_width_min(input int unsigned deb_time,
                                                input int unsigned repeat_time,
                                                input int unsigned settle_cycles);
    int unsigned max_v;
    max_v = deb_time;
    if (repeat_time > max_v) begin
      max_v = repeat_time;
    end else begin
      max_v = max_v;
    end
    if (settle_cycles > max_v) begin
      max_v = settle_cycles;
    end else begin
      max_v = max_v;
    end
    return $clog2(max_v + 32'd1);
  endfunction

endpackage

// File: rtl/trig_sync.sv
// Parameterised-width two-flop synchroniser for raw asynchronous inputs.
module trig_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Two-stage resynchronisation into the clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_r <= {WIDTH{1'b0}};
      sync_r <= {WIDTH{1'b0}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/input_trigger_seq.sv
// Button trigger sequencer: detects selected edges on synchronised inputs,
// emits an increment pulse, waits for carries to settle, emits a refresh
// pulse, then blocks further events for a debounce interval. While a
// triggering channel stays held (and repeat is enabled) it auto-repeats.
// All outputs come straight from flops loaded with next-state decodes, so
// there is no combinational path from trigger to any output.
module input_trigger_seq
  import input_trigger_pkg::*;
#(
  parameter int unsigned CHANNELS      = 6,
  parameter int unsigned DEB_TIME      = 10000,
  parameter int unsigned SETTLE_CYCLES = 10,
  parameter int unsigned REPEAT_TIME   = 500000,
  parameter int unsigned CNT_WIDTH     = 20
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] trigger,
  input  logic [CHANNELS-1:0] chan_en,
  input  logic [1:0]          edge_mode,
  input  logic                repeat_en,
  output logic [CHANNELS-1:0] inc_pulse,
  output logic                inc_clk,
  output logic                ref_clk,
  output logic                busy
);

  if (CNT_WIDTH < cnt_width_min(DEB_TIME, REPEAT_TIME, SETTLE_CYCLES)) begin : g_cnt_width_chk
    $error("input_trigger_seq: CNT_WIDTH too small for the configured intervals");
  end
  if ((DEB_TIME < 1) || (SETTLE_CYCLES < 1) || (REPEAT_TIME < 1)) begin : g_interval_chk
    $error("input_trigger_seq: interval parameters must be at least 1");
  end

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = CNT_WIDTH'(0);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] SETTLE_END = CNT_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DEB_END    = CNT_WIDTH'(DEB_TIME - 1);
  localparam logic [CNT_WIDTH-1:0] REP_END    = CNT_WIDTH'(REPEAT_TIME - 1);
  localparam logic [CHANNELS-1:0]  CH_ZERO    = {CHANNELS{1'b0}};

  logic [CHANNELS-1:0]  trig_s;
  logic [CHANNELS-1:0]  edge_s;
  logic [CHANNELS-1:0]  event_s;
  logic [CHANNELS-1:0]  held_s;
  state_e               state_r, state_s;
  logic [CNT_WIDTH-1:0] cnt_r, cnt_s;
  logic [CHANNELS-1:0]  prev_r, prev_s;
  logic [CHANNELS-1:0]  ev_r, ev_s;
  logic [CHANNELS-1:0]  inc_pulse_r, inc_pulse_s;
  logic                 inc_clk_r, inc_clk_s;
  logic                 ref_clk_r, ref_clk_s;
  logic                 busy_r, busy_s;

  trig_sync #(.WIDTH(CHANNELS)) u_trig_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (trigger),
    .q       (trig_s)
  );

  // Edge detection against the last level seen in READY, gated by the enable mask.
  always_comb begin
    edge_s = CH_ZERO;
    case (edge_mode)
      EDGE_RISE: edge_s = trig_s & ~prev_r;
      EDGE_FALL: edge_s = ~trig_s & prev_r;
      EDGE_BOTH: edge_s = trig_s ^ prev_r;
      EDGE_NONE: edge_s = CH_ZERO;
      default:   edge_s = CH_ZERO;
    endcase
    event_s = edge_s & chan_en;
    held_s  = trig_s & ev_r;
  end

  // Next-state, counter, edge history and captured-event logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    prev_s  = prev_r;
    ev_s    = ev_r;
    case (state_r)
      ST_READY: begin
        prev_s = trig_s;
        cnt_s  = CNT_ZERO;
        if (|event_s) begin
          ev_s    = event_s;
          state_s = ST_INC;
        end else begin
          state_s = ST_READY;
        end
      end
      ST_INC: begin
        cnt_s   = CNT_ZERO;
        state_s = ST_SETTLE;
      end
      ST_SETTLE: begin
        cnt_s = cnt_r + CNT_ONE;
        if (cnt_r == SETTLE_END) begin
          state_s = ST_REFRESH;
        end else begin
          state_s = ST_SETTLE;
        end
      end
      ST_REFRESH: begin
        cnt_s   = CNT_ZERO;
        state_s = ST_BLOCK;
      end
      ST_BLOCK: begin
        if (cnt_r == DEB_END) begin
          cnt_s = CNT_ZERO;
          if (repeat_en && (|held_s)) begin
            state_s = ST_HOLD;
          end else begin
            state_s = ST_READY;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_HOLD: begin
        // Release or a fresh edge wins over the repeat timeout; prev is left
        // stale so READY still sees the new edge on its first cycle.
        if ((!(|held_s)) || (|event_s)) begin
          cnt_s   = CNT_ZERO;
          state_s = ST_READY;
        end else if (cnt_r == REP_END) begin
          cnt_s   = CNT_ZERO;
          ev_s    = held_s;
          state_s = ST_INC;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        cnt_s   = CNT_ZERO;
        state_s = ST_READY;
      end
    endcase
  end

  // Output decode from the next state so the outputs can be registered.
  always_comb begin
    inc_pulse_s = CH_ZERO;
    if (state_s == ST_INC) begin
      inc_pulse_s = ev_s;
    end else begin
      inc_pulse_s = CH_ZERO;
    end
    inc_clk_s = |inc_pulse_s;
    ref_clk_s = (state_s == ST_REFRESH);
    busy_s    = (state_s != ST_READY);
  end

  // State, datapath and output registers; reset aborts any sequence at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_READY;
      cnt_r       <= CNT_ZERO;
      prev_r      <= CH_ZERO;
      ev_r        <= CH_ZERO;
      inc_pulse_r <= CH_ZERO;
      inc_clk_r   <= 1'b0;
      ref_clk_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      prev_r      <= prev_s;
      ev_r        <= ev_s;
      inc_pulse_r <= inc_pulse_s;
      inc_clk_r   <= inc_clk_s;
      ref_clk_r   <= ref_clk_s;
      busy_r      <= busy_s;
    end
  end

  assign inc_pulse = inc_pulse_r;
  assign inc_clk   = inc_clk_r;
  assign ref_clk   = ref_clk_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_input_trigger_seq.sv
// Directed testbench for input_trigger_seq with short interval parameters.
module tb_input_trigger_seq;

  logic       clk;
  logic       reset_n;
  logic [5:0] trigger;
  logic [5:0] chan_en;
  logic [1:0] edge_mode;
  logic       repeat_en;
  logic [5:0] inc_pulse;
  logic       inc_clk;
  logic       ref_clk;
  logic       busy;

  int n_checks;
  int n_fail;

  // Observation record, cycle index counted from the drive point of a test.
  int         cyc;
  int         inc_cyc[$];
  logic [5:0] inc_val[$];
  int         ref_cyc[$];
  int         busy_fall;
  logic       busy_prev;

  input_trigger_seq #(
    .CHANNELS      (6),
    .DEB_TIME      (20),
    .SETTLE_CYCLES (10),
    .REPEAT_TIME   (50),
    .CNT_WIDTH     (20)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .trigger   (trigger),
    .chan_en   (chan_en),
    .edge_mode (edge_mode),
    .repeat_en (repeat_en),
    .inc_pulse (inc_pulse),
    .inc_clk   (inc_clk),
    .ref_clk   (ref_clk),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_obs();
    cyc = 0;
    inc_cyc.delete();
    inc_val.delete();
    ref_cyc.delete();
    busy_fall = -1;
    busy_prev = busy;
  endtask

  // Advance one clock, sample 1 time unit after the edge, log pulses.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (inc_clk) begin
      inc_cyc.push_back(cyc);
      inc_val.push_back(inc_pulse);
    end
    if (ref_clk) ref_cyc.push_back(cyc);
    if (busy_prev && !busy && busy_fall < 0) busy_fall = cyc;
    busy_prev = busy;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; trigger = 6'b0; chan_en = 6'b111111;
    edge_mode = 2'b00; repeat_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (inc_pulse !== 6'b0) begin n_fail++; $display("FAIL reset_inc_pulse: got %b expected %b", inc_pulse, 6'b0); end
    n_checks++;
    if (inc_clk !== 1'b0) begin n_fail++; $display("FAIL reset_inc_clk: got %b expected 0", inc_clk); end
    n_checks++;
    if (ref_clk !== 1'b0) begin n_fail++; $display("FAIL reset_ref_clk: got %b expected 0", ref_clk); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset_n = 1'b1;
    clear_obs();
    steps(5);
    n_checks++;
    if (busy !== 1'b0 || inc_cyc.size() != 0) begin n_fail++; $display("FAIL idle_after_reset: busy %b incs %0d expected 0 0", busy, inc_cyc.size()); end
  endtask

  task automatic test_single();
    step(); clear_obs();
    trigger = 6'b000100;
    steps(40);
    n_checks++;
    if (inc_cyc.size() != 1) begin n_fail++; $display("FAIL single_inc_count: got %0d expected 1", inc_cyc.size()); end
    else begin
      n_checks++;
      if (inc_cyc[0] != 3) begin n_fail++; $display("FAIL single_latency: got %0d expected 3", inc_cyc[0]); end
      n_checks++;
      if (inc_val[0] !== 6'b000100) begin n_fail++; $display("FAIL single_pulse: got %b expected 000100", inc_val[0]); end
    end
    n_checks++;
    if (ref_cyc.size() != 1) begin n_fail++; $display("FAIL single_ref_count: got %0d expected 1", ref_cyc.size()); end
    else begin
      n_checks++;
      if (ref_cyc[0] != 14) begin n_fail++; $display("FAIL single_ref_cycle: got %0d expected 14", ref_cyc[0]); end
    end
    n_checks++;
    if (busy_fall != 35) begin n_fail++; $display("FAIL single_busy_fall: got %0d expected 35", busy_fall); end
    trigger = 6'b0;
    steps(6);
    n_checks++;
    if (busy !== 1'b0 || inc_cyc.size() != 1) begin n_fail++; $display("FAIL single_release: busy %b incs %0d expected 0 1", busy, inc_cyc.size()); end
  endtask

  task automatic test_simultaneous();
    step(); clear_obs();
    trigger = 6'b100001;
    steps(40);
    n_checks++;
    if (inc_cyc.size() != 1) begin n_fail++; $display("FAIL simul_inc_count: got %0d expected 1", inc_cyc.size()); end
    else begin
      n_checks++;
      if (inc_val[0] !== 6'b100001) begin n_fail++; $display("FAIL simul_pulse: got %b expected 100001", inc_val[0]); end
      n_checks++;
      if (inc_cyc[0] != 3) begin n_fail++; $display("FAIL simul_latency: got %0d expected 3", inc_cyc[0]); end
    end
    trigger = 6'b0;
    steps(6);
  endtask

  task automatic test_edge_modes();
    edge_mode = 2'b01;
    steps(2);
    step(); clear_obs();
    trigger = 6'b000010;
    steps(5);
    trigger = 6'b0;
    steps(40);
    n_checks++;
    if (inc_cyc.size() != 1) begin n_fail++; $display("FAIL falling_inc_count: got %0d expected 1", inc_cyc.size()); end
    else begin
      n_checks++;
      if (inc_cyc[0] != 8) begin n_fail++; $display("FAIL falling_cycle: got %0d expected 8", inc_cyc[0]); end
      n_checks++;
      if (inc_val[0] !== 6'b000010) begin n_fail++; $display("FAIL falling_pulse: got %b expected 000010", inc_val[0]); end
    end
    edge_mode = 2'b11;
    steps(2);
    clear_obs();
    trigger = 6'b000010;
    steps(5);
    trigger = 6'b0;
    steps(20);
    n_checks++;
    if (inc_cyc.size() != 0) begin n_fail++; $display("FAIL mode_none_inc_count: got %0d expected 0", inc_cyc.size()); end
    edge_mode = 2'b00;
    steps(3);
  endtask

  task automatic test_chan_en();
    chan_en = 6'b111110;
    step(); clear_obs();
    trigger = 6'b000001;
    steps(12);
    n_checks++;
    if (inc_cyc.size() != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL chan_disabled: incs %0d busy %b expected 0 0", inc_cyc.size(), busy); end
    trigger = 6'b0;
    steps(5);
    chan_en = 6'b111111;
    steps(2);
  endtask

  task automatic test_repeat();
    repeat_en = 1'b1;
    step(); clear_obs();
    trigger = 6'b001000;
    steps(200);
    trigger = 6'b0;
    steps(60);
    n_checks++;
    if (inc_cyc.size() != 3) begin n_fail++; $display("FAIL repeat_inc_count: got %0d expected 3", inc_cyc.size()); end
    else begin
      n_checks++;
      if (inc_cyc[0] != 3 || inc_cyc[1] != 85 || inc_cyc[2] != 167) begin
        n_fail++; $display("FAIL repeat_cycles: got %0d %0d %0d expected 3 85 167", inc_cyc[0], inc_cyc[1], inc_cyc[2]);
      end
    end
    for (int i = 0; i < inc_val.size(); i++) begin
      n_checks++;
      if (inc_val[i] !== 6'b001000) begin n_fail++; $display("FAIL repeat_pulse: got %b expected 001000", inc_val[i]); end
    end
    n_checks++;
    if (busy_fall != 203) begin n_fail++; $display("FAIL repeat_release: busy fell at %0d expected 203", busy_fall); end
    repeat_en = 1'b0;
    steps(2);
  endtask

  task automatic test_bounce();
    step(); clear_obs();
    trigger = 6'b010000;
    steps(15);
    for (int k = 0; k < 14; k++) begin
      step();
      trigger[4] = (cyc % 2 == 1);
    end
    steps(40);
    n_checks++;
    if (inc_cyc.size() != 1) begin n_fail++; $display("FAIL bounce_inc_count: got %0d expected 1", inc_cyc.size()); end
    n_checks++;
    if (busy_fall != 35) begin n_fail++; $display("FAIL bounce_busy_fall: got %0d expected 35", busy_fall); end
    trigger = 6'b0;
    steps(6);
  endtask

  task automatic test_reset_mid();
    step(); clear_obs();
    trigger = 6'b000100;
    steps(8);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
    reset_n = 1'b0;
    trigger = 6'b0;
    #1;
    n_checks++;
    if ({inc_pulse, inc_clk, ref_clk, busy} !== 9'b0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got %b expected %b", {inc_pulse, inc_clk, ref_clk, busy}, 9'b0);
    end
    steps(3);
    reset_n = 1'b1;
    steps(40);
    n_checks++;
    if (ref_cyc.size() != 0) begin n_fail++; $display("FAIL mid_reset_ref: got %0d pulses expected 0", ref_cyc.size()); end
    n_checks++;
    if (inc_cyc.size() != 1 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_after: incs %0d busy %b expected 1 0", inc_cyc.size(), busy); end
  endtask

  task automatic test_reset_held_high();
    trigger = 6'b000001;
    reset_n = 1'b0;
    steps(3);
    clear_obs();
    reset_n = 1'b1;
    steps(10);
    n_checks++;
    if (inc_cyc.size() != 1) begin n_fail++; $display("FAIL held_reset_count: got %0d expected 1", inc_cyc.size()); end
    else begin
      n_checks++;
      if (inc_cyc[0] != 3 || inc_val[0] !== 6'b000001) begin
        n_fail++; $display("FAIL held_reset_event: cycle %0d pulse %b expected 3 000001", inc_cyc[0], inc_val[0]);
      end
    end
    trigger = 6'b0;
    steps(40);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_simultaneous();
    test_edge_modes();
    test_chan_en();
    test_repeat();
    test_bounce();
    test_reset_mid();
    test_reset_held_high();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
